// File: rtl/multicycle_core_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core.
package core_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } alu_op_t;

    typedef enum logic [1:0] {
        FETCH, EXEC, WB, HALT
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // alt selects SUB on funct3 000 and SRA on funct3 101
    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return alt ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction-fetch bus between the core (master) and instruction memory (slave).
interface multicycle_core_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/multicycle_core_alu.sv
// Combinational integer ALU; shifts use the low log2(XLEN) bits of b.
module core_alu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] result
);
    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = b[SW-1:0];

    always_comb begin
        result = '0;
        case (alu_op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            SLL:     result = a << shamt;
            SLT:     result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU:    result = {{(XLEN-1){1'b0}}, a < b};
            XOR:     result = a ^ b;
            SRL:     result = a >> shamt;
            SRA:     result = $unsigned($signed(a) >>> shamt);
            OR:      result = a | b;
            AND:     result = a & b;
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle FETCH/EXEC/WB core with trace port; halts on illegal instructions.
// Define MULTICYCLE_CORE_BRANCH_EN to build BEQ/BNE support.
module multicycle_core
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_core_if.master   imem,
    output logic                retire_valid,
    output logic [XLEN-1:0]     retire_pc,
    output logic [4:0]          retire_rd,
    output logic [XLEN-1:0]     retire_data,
    output logic                halted
);
    localparam int RW = $clog2(NREGS);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, next_pc_q, result_q;
    logic [31:0]     ir_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] regs_q [NREGS];

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u, op_a, op_b, alu_res, next_pc;
    logic            illegal, writes, use_rs1, use_rs2, wr_en, is_lui;
    alu_op_t         alu_op;

    assign opcode  = ir_q[6:0];
    assign rd      = ir_q[11:7];
    assign f3      = ir_q[14:12];
    assign rs1     = ir_q[19:15];
    assign rs2     = ir_q[24:20];
    assign f7      = ir_q[31:25];
    assign imm_i   = XLEN'($signed(ir_q[31:20]));
    assign imm_u   = XLEN'($signed({ir_q[31:12], 12'b0}));
    assign rs1_val = regs_q[rs1[RW-1:0]];
    assign rs2_val = regs_q[rs2[RW-1:0]];

    always_comb begin
        illegal = 1'b1;
        writes  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_lui  = 1'b0;
        alu_op  = ADD;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
                illegal = !(f7 == 7'b0000000 ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                alu_op  = alu_from_f3(f3, f7[5]);
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                writes  = 1'b1;
                illegal = 1'b0;
                if (f3 == 3'b001) illegal = (f7 != 7'b0000000);
                if (f3 == 3'b101) illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
                // funct7 only distinguishes SRAI; ADDI's upper immediate must not select SUB
                alu_op  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
            end
            OPC_LUI: begin
                writes  = 1'b1;
                is_lui  = 1'b1;
                illegal = 1'b0;
            end
`ifdef MULTICYCLE_CORE_BRANCH_EN
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                illegal = (f3[2:1] != 2'b00);
            end
`endif
            default: illegal = 1'b1;
        endcase
        if ((use_rs1 && 32'(rs1) >= NREGS) || (use_rs2 && 32'(rs2) >= NREGS) ||
            (writes && 32'(rd) >= NREGS))
            illegal = 1'b1;
    end

    assign wr_en = writes && (rd != 5'd0);
    assign op_a  = is_lui ? '0 : rs1_val;
    assign op_b  = use_rs2 ? rs2_val : (is_lui ? imm_u : imm_i);

    core_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (alu_op),
        .result (alu_res)
    );

`ifdef MULTICYCLE_CORE_BRANCH_EN
    logic [XLEN-1:0] imm_b;
    logic            br_taken;
    assign imm_b    = XLEN'($signed({ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0}));
    assign br_taken = (opcode == OPC_BRANCH) && ((rs1_val == rs2_val) != f3[0]);
    assign next_pc  = br_taken ? ((pc_q + imm_b) & ~XLEN'(3)) : (pc_q + XLEN'(4));
`else
    assign next_pc  = pc_q + XLEN'(4);
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (imem.imem_valid) state_d = EXEC;
            EXEC:    state_d = illegal ? HALT : WB;
            WB:      state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state_q == FETCH) && !reset;
        imem.imem_addr = pc_q;
        retire_valid   = (state_q == WB);
        retire_pc      = (state_q == WB) ? pc_q : '0;
        retire_rd      = (state_q == WB) ? rd_q : 5'd0;
        retire_data    = (state_q == WB) ? result_q : '0;
        halted         = (state_q == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            next_pc_q <= '0;
            result_q  <= '0;
            ir_q      <= '0;
            rd_q      <= 5'd0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                FETCH: if (imem.imem_valid) ir_q <= imem.imem_rdata;
                EXEC: begin
                    result_q  <= wr_en ? alu_res : '0;
                    rd_q      <= wr_en ? rd : 5'd0;
                    next_pc_q <= next_pc;
                end
                WB: begin
                    pc_q <= next_pc_q;
                    // rd_q is nonzero only for a legal write, so x0 stays zero
                    if (rd_q != 5'd0) regs_q[rd_q[RW-1:0]] <= result_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: ALU ops, fetch stalls, x0, branch/halt, reset, NREGS=16.
module tb_multicycle_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset2;
    multicycle_core_if #(.XLEN(32)) bus  ();
    multicycle_core_if #(.XLEN(32)) bus2 ();

    logic        rv, halted, rv2, halted2;
    logic [31:0] rpc, rdata, rpc2, rdata2;
    logic [4:0]  rrd, rrd2;

    int total = 0;
    int bad   = 0;

    multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .retire_valid(rv), .retire_pc(rpc), .retire_rd(rrd),
        .retire_data(rdata), .halted(halted)
    );

    multicycle_core #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut16 (
        .clk(clk), .reset(reset2), .imem(bus2),
        .retire_valid(rv2), .retire_pc(rpc2), .retire_rd(rrd2),
        .retire_data(rdata2), .halted(halted2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a posedge with the core in FETCH; leaves it back in FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [31:0] pc,
                             input logic [4:0] erd, input logic [31:0] edata);
        @(negedge clk);
        check("fetch_req", 32'(bus.imem_req), 1);
        check("fetch_addr", bus.imem_addr, pc);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = instr;
        @(posedge clk); #1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        @(negedge clk);
        check("exec_no_retire", 32'(rv), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("retire_valid", 32'(rv), 1);
        check("retire_pc", rpc, pc);
        check("retire_rd", 32'(rrd), 32'(erd));
        check("retire_data", rdata, edata);
        $display("instr %h pc=%h rd=%0d data=%h", instr, rpc, rrd, rdata);
        @(posedge clk); #1;
    endtask

    task automatic halt_instr(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        check("halt_fetch_addr", bus.imem_addr, pc);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = instr;
        @(posedge clk); #1;
        bus.imem_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halted", 32'(halted), 1);
            check("halt_req", 32'(bus.imem_req), 0);
            check("halt_no_retire", 32'(rv), 0);
            @(posedge clk); #1;
        end
        $display("instr %h pc=%h halted=%0d", instr, pc, halted);
    endtask

    initial begin
        reset = 1'b1;
        reset2 = 1'b1;
        bus.imem_valid = 1'b0;  bus.imem_rdata = 32'h0;
        bus2.imem_valid = 1'b0; bus2.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_retire", 32'(rv), 0);
        check("rst_halted", 32'(halted), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(32'h00500093, 32'd0,  5'd1, 32'd5);         // addi x1,x0,5
        run_instr(32'hFF800093, 32'd4,  5'd1, 32'hFFFFFFF8);  // addi x1,x0,-8
        run_instr(32'h4010D113, 32'd8,  5'd2, 32'hFFFFFFFC);  // srai x2,x1,1
        run_instr(32'h0010D113, 32'd12, 5'd2, 32'h7FFFFFFC);  // srli x2,x1,1
        run_instr(32'h001031B3, 32'd16, 5'd3, 32'd1);         // sltu x3,x0,x1
        run_instr(32'h0000A1B3, 32'd20, 5'd3, 32'd1);         // slt x3,x1,x0

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req", 32'(bus.imem_req), 1);
            check("stall_addr", bus.imem_addr, 32'd24);
            check("stall_no_retire", 32'(rv), 0);
            @(posedge clk); #1;
        end
        run_instr(32'h00208233, 32'd24, 5'd4, 32'h7FFFFFF4);  // add x4,x1,x2
        run_instr(32'h40110333, 32'd28, 5'd6, 32'h80000004);  // sub x6,x2,x1
        run_instr(32'h00700013, 32'd32, 5'd0, 32'd0);         // addi x0,x0,7
        run_instr(32'h000002B3, 32'd36, 5'd5, 32'd0);         // add x5,x0,x0
        run_instr(32'h800003B7, 32'd40, 5'd7, 32'h80000000);  // lui x7,0x80000
        run_instr(32'hFFF0C413, 32'd44, 5'd8, 32'd7);         // xori x8,x1,-1
        run_instr(32'h00409493, 32'd48, 5'd9, 32'hFFFFFF80);  // slli x9,x1,4

`ifdef MULTICYCLE_CORE_BRANCH_EN
        run_instr(32'h00000463, 32'd52, 5'd0, 32'd0);         // beq x0,x0,+8
        halt_instr(32'h00000000, 32'd60);
`else
        halt_instr(32'h00000463, 32'd52);
`endif

        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_halted", 32'(halted), 0);
        @(posedge clk); #1;
        run_instr(32'h000085B3, 32'd0, 5'd11, 32'd0);         // add x11,x1,x0 after reset
        halt_instr(32'h40001033, 32'd4);                      // sll with funct7 0100000

        reset2 = 1'b0;
        @(negedge clk);
        check("n16_req", 32'(bus2.imem_req), 1);
        bus2.imem_valid = 1'b1;
        bus2.imem_rdata = 32'h00300793;                       // addi x15,x0,3
        @(posedge clk); #1;
        bus2.imem_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("n16_retire", 32'(rv2), 1);
        check("n16_rd", 32'(rrd2), 15);
        check("n16_data", rdata2, 3);
        $display("n16 instr 00300793 rd=%0d data=%h", rrd2, rdata2);
        @(posedge clk); #1;
        bus2.imem_valid = 1'b1;
        bus2.imem_rdata = 32'h00100A13;                       // addi x20,x0,1
        @(posedge clk); #1;
        bus2.imem_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("n16_halted", 32'(halted2), 1);
        check("n16_halt_req", 32'(bus2.imem_req), 0);
        $display("n16 instr 00100a13 halted=%0d", halted2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
